m_stage_dm: RTL and testbench

- Memory-stage data memory for the 5-stage MIPS pipeline.
- Performs word, halfword and byte loads and stores with byte-lane masking and load sign/zero extension.
- Produces the load result the M/W pipeline register captures as M_DM_out.
- Keeps a committed-store counter for bench and trace checking.

---
 rtl/m_stage_dm.sv | 61 ++++++
 tb/tb_m_stage_dm.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/m_stage_dm.sv
// m_stage_dm: MIPS M-stage data memory with byte-lane stores, extended loads and a store counter
module m_stage_dm #(
  parameter int DEPTH_WORDS = 3072,
  parameter int IDX_BITS    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [2:0]  acc_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc_m,
  output logic [31:0] rdata,
  output logic [31:0] store_cnt,
  output logic [31:0] last_store_pc
);
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_store_cnt, r_last_store_pc;
  logic [IDX_BITS-1:0] w_idx;
  logic w_in_range, w_half, w_byte, w_commit;
  logic [3:0] w_be;
  logic [31:0] w_wd, w_old, w_new;
  logic [15:0] w_hsel;
  logic [7:0] w_bsel;
  assign w_idx      = addr[IDX_BITS+1:2];
  assign w_in_range = addr < 32'(4 * DEPTH_WORDS);
  assign w_half     = acc_op == 3'd1 || acc_op == 3'd2;
  assign w_byte     = acc_op == 3'd3 || acc_op == 3'd4;
  assign w_commit   = mem_write && !reset && w_in_range;
  assign w_old      = w_in_range ? r_mem[w_idx] : '0;
  assign w_be = w_byte ? 4'b0001 << addr[1:0] : w_half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wd = w_byte ? {4{wdata[7:0]}} : w_half ? {2{wdata[15:0]}} : wdata;
  always_comb begin
    w_new = w_old;
    for (int k = 0; k < 4; k++) w_new[8*k +: 8] = w_be[k] ? w_wd[8*k +: 8] : w_old[8*k +: 8];
  end
  assign w_hsel = addr[1] ? w_old[31:16] : w_old[15:0];
  assign w_bsel = w_old[{addr[1:0], 3'b000} +: 8];
  // Reads see pre-edge contents, so a same-cycle store to the same word returns old data
  always_comb begin
    rdata = reset           ? 32'h0 :
            acc_op == 3'd1 ? {16'h0, w_hsel} :
            acc_op == 3'd2 ? {{16{w_hsel[15]}}, w_hsel} :
            acc_op == 3'd3 ? {24'h0, w_bsel} :
            acc_op == 3'd4 ? {{24{w_bsel[7]}}, w_bsel} :
            w_old;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
      r_store_cnt     <= '0;
      r_last_store_pc <= 32'h0000_3000;
    end else if (w_commit) begin
      r_mem[w_idx]    <= w_new;
      r_store_cnt     <= r_store_cnt + 32'd1;
      r_last_store_pc <= pc_m;
    end
  end
  assign store_cnt     = r_store_cnt;
  assign last_store_pc = r_last_store_pc;
endmodule

// File: tb/tb_m_stage_dm.sv
// tb_m_stage_dm: directed vector table plus randomized run against a byte-array memory model
module tb_m_stage_dm;
  logic        clk = 0;
  logic        reset = 1;
  logic        mem_write = 0;
  logic [2:0]  acc_op = 0;
  logic [31:0] addr = 0, wdata = 0, pc_m = 0;
  logic [31:0] rdata, store_cnt, last_store_pc;

  int checks = 0;
  int errors = 0;

  localparam int NBYTES = 4 * 3072;
  logic [7:0]  mb [NBYTES];
  logic [31:0] m_cnt, m_pc;

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  op;
    logic [31:0] a, wd, pc, er, ec, ep;
  } vec_t;
  vec_t vecs[$];

  m_stage_dm dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .acc_op(acc_op), .addr(addr),
    .wdata(wdata), .pc_m(pc_m), .rdata(rdata), .store_cnt(store_cnt), .last_store_pc(last_store_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic we, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                      input logic [31:0] er, input logic [31:0] ec, input logic [31:0] ep);
    @(negedge clk);
    reset = rst; mem_write = we; acc_op = op; addr = a; wdata = wd; pc_m = pc;
    #1 chk({tag, " rdata"}, rdata, er);
    @(posedge clk);
    #1;
    chk({tag, " store_cnt"}, store_cnt, ec);
    chk({tag, " last_store_pc"}, last_store_pc, ep);
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] b;
    logic [15:0] h;
    if (a >= NBYTES) return 0;
    if (op == 1 || op == 2) begin
      b = a & ~32'd1;
      h = {mb[b+1], mb[b]};
      return op == 2 ? 32'($signed(h)) : {16'h0, h};
    end
    if (op == 3) return {24'h0, mb[a]};
    if (op == 4) return 32'($signed(mb[a]));
    b = a & ~32'd3;
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] wd,
                         input logic [31:0] pc);
    logic [31:0] b;
    if (a >= NBYTES) return;
    if (op == 1 || op == 2) begin
      b = a & ~32'd1;
      mb[b] = wd[7:0]; mb[b+1] = wd[15:8];
    end else if (op == 3 || op == 4) mb[a] = wd[7:0];
    else begin
      b = a & ~32'd3;
      for (int j = 0; j < 4; j++) mb[b+j] = wd[8*j +: 8];
    end
    m_cnt = m_cnt + 1;
    m_pc = pc;
  endtask

  task automatic m_reset();
    for (int j = 0; j < NBYTES; j++) mb[j] = 0;
    m_cnt = 0;
    m_pc = 32'h3000;
  endtask

  initial begin
    //              rst   we    op   addr           wdata          pc             rdata          cnt    last_pc
    vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h0000_0000, 32'h0,         32'h0,         32'h0,         32'd0, 32'h3000});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h0,         32'h0,         32'h0,         32'd0, 32'h3000});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0000_2FFC, 32'h0,         32'h0,         32'h0,         32'd0, 32'h3000});
    vecs.push_back('{1'b0, 1'b1, 3'd0, 32'h0000_0010, 32'h89ABCDEF,  32'h3004,      32'h0,         32'd1, 32'h3004});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0000_0010, 32'h0,         32'h0,         32'h89ABCDEF,  32'd1, 32'h3004});
    vecs.push_back('{1'b0, 1'b1, 3'd3, 32'h0000_0012, 32'h0000_00AA, 32'h3008,      32'h0000_00AB, 32'd2, 32'h3008});
    vecs.push_back('{1'b0, 1'b1, 3'd1, 32'h0000_0010, 32'h0000_1234, 32'h300C,      32'h0000_CDEF, 32'd3, 32'h300C});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0000_0010, 32'h0,         32'h0,         32'h89AA1234,  32'd3, 32'h300C});
    vecs.push_back('{1'b0, 1'b0, 3'd4, 32'h0000_0012, 32'h0,         32'h0,         32'hFFFFFFAA,  32'd3, 32'h300C});
    vecs.push_back('{1'b0, 1'b0, 3'd3, 32'h0000_0012, 32'h0,         32'h0,         32'h000000AA,  32'd3, 32'h300C});
    vecs.push_back('{1'b0, 1'b0, 3'd2, 32'h0000_0012, 32'h0,         32'h0,         32'hFFFF89AA,  32'd3, 32'h300C});
    vecs.push_back('{1'b0, 1'b0, 3'd1, 32'h0000_0012, 32'h0,         32'h0,         32'h000089AA,  32'd3, 32'h300C});
    vecs.push_back('{1'b0, 1'b1, 3'd0, 32'h0000_3000, 32'hDEADBEEF,  32'h3010,      32'h0,         32'd3, 32'h300C});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h0,         32'h0,         32'h0,         32'd3, 32'h300C});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0000_3000, 32'h0,         32'h0,         32'h0,         32'd3, 32'h300C});
    vecs.push_back('{1'b1, 1'b1, 3'd0, 32'h0000_0020, 32'h0000_0055, 32'h3014,      32'h0,         32'd0, 32'h3000});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0000_0020, 32'h0,         32'h0,         32'h0,         32'd0, 32'h3000});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0000_0010, 32'h0,         32'h0,         32'h0,         32'd0, 32'h3000});
    vecs.push_back('{1'b0, 1'b1, 3'd2, 32'h0000_0023, 32'h1234ABCD,  32'h3020,      32'h0,         32'd1, 32'h3020});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0000_0020, 32'h0,         32'h0,         32'hABCD0000,  32'd1, 32'h3020});
    vecs.push_back('{1'b0, 1'b1, 3'd4, 32'h0000_2FFF, 32'h0000_0077, 32'h3024,      32'h0,         32'd2, 32'h3024});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0000_2FFC, 32'h0,         32'h0,         32'h77000000,  32'd2, 32'h3024});
    vecs.push_back('{1'b0, 1'b0, 3'd4, 32'h0000_2FFF, 32'h0,         32'h0,         32'h00000077,  32'd2, 32'h3024});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h8000_0020, 32'h0,         32'h0,         32'h0,         32'd2, 32'h3024});
    vecs.push_back('{1'b0, 1'b1, 3'd5, 32'h0000_0033, 32'h01020304,  32'h3028,      32'h0,         32'd3, 32'h3028});
    vecs.push_back('{1'b0, 1'b0, 3'd7, 32'h0000_0030, 32'h0,         32'h0,         32'h01020304,  32'd3, 32'h3028});

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].we, vecs[i].op, vecs[i].a, vecs[i].wd,
           vecs[i].pc, vecs[i].er, vecs[i].ec, vecs[i].ep);

    // Randomized run: start from a clean reset so the model and DUT agree
    m_reset();
    step("rnd_reset", 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd0, 32'h3000);
    for (int n = 0; n < 400; n++) begin
      logic rst, we;
      logic [2:0] op;
      logic [31:0] a, wd, pc, er;
      int r;
      r = $urandom_range(0, 9);
      a = r < 7 ? 32'($urandom_range(0, 63)) :
          r < 9 ? 32'(NBYTES - 64 + $urandom_range(0, 127)) : $urandom();
      rst = $urandom_range(0, 39) == 0;
      we = $urandom_range(0, 1) == 1;
      op = 3'($urandom_range(0, 7));
      wd = $urandom();
      pc = $urandom();
      er = rst ? 32'h0 : m_load(a, op);
      if (rst) m_reset();
      else if (we) m_store(a, op, wd, pc);
      step($sformatf("rnd%0d", n), rst, we, op, a, wd, pc, er, m_cnt, m_pc);
    end

    // Counter wrap from the all-ones value
    @(negedge clk);
    mem_write = 0;
    force dut.r_store_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_store_cnt;
    step("wrap", 1'b0, 1'b1, 3'd0, 32'h0000_0040, 32'h0BAD_F00D, 32'h0000_4000,
         m_load(32'h40, 3'd0), 32'd0, 32'h0000_4000);
    step("wrap_data", 1'b0, 1'b0, 3'd0, 32'h0000_0040, 32'h0, 32'h0,
         32'h0BAD_F00D, 32'd0, 32'h0000_4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
